dmem_arbiter: RTL

- Shares the single data memory port between two requesters: the CPU load/store path (port C) and an external loader/debug port (port E).
- Uses a 3-state FSM with fixed CPU priority and a starvation counter that guarantees port E service.
- Drives the memory's address, write-data and write-enable, and returns registered read data with a one-cycle ack.
- Provides a stall signal the top level uses to freeze PC while a CPU access is outstanding.

---
 rtl/dmem_arb_pkg.sv | 26 ++
 rtl/dmem_arbiter_if.sv | 61 ++++++
 rtl/dmem_arbiter_arb_select.sv | 50 +++++
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_pkg
//  Description : Shared types and constants for the data-memory arbiter.
//                FSM state encoding, owner codes and the starvation counter
//                width.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_t;

    // Width of the starvation counter; holds any MAX_WAIT in 1..15.
    localparam int unsigned c_wait_w = 4;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : Bundle of the CPU port (C), the external loader/debug port
//                (E) and the data-memory port around dmem_arbiter.
//                  master : arbiter view (takes requests, drives acks, read
//                           data, stall, busy and the memory address/data/we)
//                  slave  : environment view (requesters and memory)
//  Ports       : cpu_req/we/addr/wdata -> cpu_ack/rdata/stall
//                ext_req/we/addr/wdata -> ext_ack/rdata
//                mem_addr/wdata/we     <- mem_rdata, busy
//  Revision    : 1.0  initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    logic          ext_req;
    logic          ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_ack;
    logic [DW-1:0] ext_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_stall,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_ack, ext_rdata,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata,
        output busy
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_stall,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_ack, ext_rdata,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata,
        input  busy
    );

endinterface : dmem_arbiter_if
`default_nettype wire

// File: rtl/dmem_arbiter_arb_select.sv
`default_nettype none
// ============================================================================
//  Module      : arb_select
//  Description : Winner selection for the data-memory arbiter. CPU has fixed
//                priority, but once it has won MAX_WAIT times in a row while
//                E was waiting, E is forced through on the next pick.
//  Ports       : clk, rst       clock, async active-high reset
//                i_cpu_req      CPU request
//                i_ext_req      external request
//                i_pick         a winner is being latched this cycle
//                o_pick_ext     1 = E wins, 0 = C wins (valid with i_pick)
//  Revision    : 1.0  initial release
// ============================================================================
module arb_select
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4   // legal range 1..15
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_cpu_req,
    input  wire logic i_ext_req,
    input  wire logic i_pick,
    output logic      o_pick_ext
);

    localparam logic [c_wait_w-1:0] c_max_wait = c_wait_w'(MAX_WAIT);

    // Consecutive CPU wins taken while E was pending.
    logic [c_wait_w-1:0] r_wait_cnt;

    // E wins when it is alone, or when it has been passed over MAX_WAIT times.
    always_comb begin
        o_pick_ext = i_ext_req && (!i_cpu_req || (r_wait_cnt == c_max_wait));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (i_pick) begin
            if (o_pick_ext) begin
                r_wait_cnt <= '0;
            end else if (i_ext_req && (r_wait_cnt != c_max_wait)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

endmodule : arb_select
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares one data-memory port between the CPU load/store path
//                (C) and an external loader/debug port (E). A 3-state FSM
//                (IDLE -> ACCESS -> RESP) latches the winner's request,
//                performs the memory access and returns a one-cycle ack with
//                registered read data.
//  Ports       : clk  clock (rising edge)
//                rst  asynchronous active-high reset
//                bus  dmem_arbiter_if.master: C/E request ports, memory port,
//                     cpu_stall and busy
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int          AW       = 32,
    parameter int          DW       = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    dmem_arbiter_if.master  bus
);

    state_t        r_state;
    state_t        w_state_next;
    owner_t        r_owner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_ext_rdata;

    logic          w_pick;
    logic          w_pick_ext;
    logic          w_mem_we;
    logic          w_cpu_ack;
    logic          w_ext_ack;
    logic          w_busy;

    // A new access is accepted only from IDLE.
    assign w_pick = (r_state == ST_IDLE) && (bus.cpu_req || bus.ext_req);

    arb_select #(
        .MAX_WAIT (MAX_WAIT)
    ) u_sel (
        .clk        (clk),
        .rst        (rst),
        .i_cpu_req  (bus.cpu_req),
        .i_ext_req  (bus.ext_req),
        .i_pick     (w_pick),
        .o_pick_ext (w_pick_ext)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mem_we     = 1'b0;
        w_cpu_ack    = 1'b0;
        w_ext_ack    = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (w_pick) begin
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_mem_we     = r_we;
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                w_cpu_ack    = (r_owner == OWN_CPU);
                w_ext_ack    = (r_owner == OWN_EXT);
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    // The request payload is sampled only on the IDLE pick edge; later
    // changes on the requester side have no effect on the access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner     <= OWN_CPU;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_ext_rdata <= '0;
        end else begin
            if (w_pick) begin
                if (w_pick_ext) begin
                    r_owner <= OWN_EXT;
                    r_addr  <= bus.ext_addr;
                    r_wdata <= bus.ext_wdata;
                    r_we    <= bus.ext_we;
                end else begin
                    r_owner <= OWN_CPU;
                    r_addr  <= bus.cpu_addr;
                    r_wdata <= bus.cpu_wdata;
                    r_we    <= bus.cpu_we;
                end
            end
            // Loads capture into the owner's register only; writes leave
            // both read-data registers untouched.
            if ((r_state == ST_ACCESS) && !r_we) begin
                if (r_owner == OWN_CPU) begin
                    r_cpu_rdata <= bus.mem_rdata;
                end else begin
                    r_ext_rdata <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_we    = w_mem_we;
    assign bus.cpu_ack   = w_cpu_ack;
    assign bus.ext_ack   = w_ext_ack;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.ext_rdata = r_ext_rdata;
    assign bus.busy      = w_busy;
    // Stall from the request cycle until the ack cycle, where the CPU moves on.
    assign bus.cpu_stall = bus.cpu_req & ~w_cpu_ack;

endmodule : dmem_arbiter
`default_nettype wire
